// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART baud generation path.
// Widths here are the default configuration; blocks re-derive from their own parameters.
package uart_pkg;

    localparam int DL_WIDTH_DEF     = 16;
    localparam int PSD_WIDTH_DEF    = 4;
    localparam int FRAC_WIDTH_DEF   = 4;
    localparam int PERIOD_WIDTH_DEF = DL_WIDTH_DEF + PSD_WIDTH_DEF + 1;

    typedef logic [PERIOD_WIDTH_DEF-1:0] period_t;
    typedef logic [DL_WIDTH_DEF-1:0]     dl_word_t;
    typedef logic [3:0]                  phase_t;

    typedef enum logic [1:0] {
        OSR_16 = 2'd0,
        OSR_8  = 2'd1,
        OSR_4  = 2'd2
    } osr_sel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Last phase value before the baud phase wraps; the reserved code behaves as 16x.
    function automatic phase_t osr_last_phase(input osr_sel_t sel);
        phase_t last;
        case (sel)
            OSR_8:   last = 4'd7;
            OSR_4:   last = 4'd3;
            default: last = 4'd15;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/shift_mult.sv
// Serial shift-and-add multiplier: one multiplier bit per cycle, done pulses
// for one cycle with the product valid.
module shift_mult #(
    parameter int A_WIDTH = 17,
    parameter int B_WIDTH = 5,
    parameter int P_WIDTH = A_WIDTH + B_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               srst,
    input  logic               start,
    input  logic [A_WIDTH-1:0] multiplicand,
    input  logic [B_WIDTH-1:0] multiplier,
    output logic [P_WIDTH-1:0] product,
    output logic               done
);

    localparam int CW = $clog2(B_WIDTH + 1);

    logic [P_WIDTH-1:0] mcand_r;
    logic [B_WIDTH-1:0] mplier_r;
    logic [P_WIDTH-1:0] acc_r;
    logic [CW-1:0]      cnt_r;
    logic               run_r;
    logic               done_r;

    // Iterate over multiplier bits; a new start always aborts the current run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r  <= {P_WIDTH{1'b0}};
            mplier_r <= {B_WIDTH{1'b0}};
            acc_r    <= {P_WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
            run_r    <= 1'b0;
            done_r   <= 1'b0;
        end else if (srst) begin
            mcand_r  <= {P_WIDTH{1'b0}};
            mplier_r <= {B_WIDTH{1'b0}};
            acc_r    <= {P_WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
            run_r    <= 1'b0;
            done_r   <= 1'b0;
        end else if (start) begin
            mcand_r  <= {{(P_WIDTH-A_WIDTH){1'b0}}, multiplicand};
            mplier_r <= multiplier;
            acc_r    <= {P_WIDTH{1'b0}};
            cnt_r    <= CW'(B_WIDTH);
            run_r    <= 1'b1;
            done_r   <= 1'b0;
        end else if (run_r) begin
            if (mplier_r[0]) begin
                acc_r <= acc_r + mcand_r;
            end
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r - CW'(1);
            if (cnt_r == CW'(1)) begin
                run_r  <= 1'b0;
                done_r <= 1'b1;
            end else begin
                done_r <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign product = acc_r;
    assign done    = done_r;

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional baud generator: sample_tick every N or N+1 cycles (DLD dithering),
// baud_tick on every OSR-th sample event, N computed serially after each recompute.
module baud_gen_frac
    import uart_pkg::*;
#(
    parameter int DL_WIDTH   = DL_WIDTH_DEF,
    parameter int PSD_WIDTH  = PSD_WIDTH_DEF,
    parameter int FRAC_WIDTH = FRAC_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DL_WIDTH-1:0]   divisor_latch,
    input  logic [PSD_WIDTH-1:0]  psd,
    input  logic [FRAC_WIDTH-1:0] dld,
    input  logic [1:0]            osr_sel,
    input  logic                  new_baud,
    input  logic                  enable_sample,
    input  logic                  enable_baud,
    output logic                  sample_tick,
    output logic                  baud_tick,
    output logic                  active,
    output logic                  busy
);

    localparam int P_W = DL_WIDTH + PSD_WIDTH + 1;
    localparam int A_W = DL_WIDTH + 1;
    localparam int B_W = PSD_WIDTH + 1;
    localparam logic [P_W-1:0] ONE_P = {{(P_W-1){1'b0}}, 1'b1};

    state_t                state_r;
    state_t                next_state_s;
    logic                  calc_start_r;
    logic [FRAC_WIDTH-1:0] dld_r;
    osr_sel_t              osr_r;
    logic [P_W-1:0]        period_r;
    logic [P_W-1:0]        cnt_r;
    logic [FRAC_WIDTH-1:0] acc_r;
    logic                  extra_r;
    phase_t                phase_r;
    logic                  sample_tick_r;
    logic                  baud_tick_r;
    logic                  active_r;
    logic                  busy_r;

    logic [A_W-1:0]        mcand_s;
    logic [B_W-1:0]        mplier_s;
    logic [P_W-1:0]        product_s;
    logic                  mult_done_s;
    logic [FRAC_WIDTH:0]   frac_sum_s;
    logic [P_W-1:0]        reload_s;
    logic                  count_en_s;
    logic                  event_s;
    phase_t                last_phase_s;
    logic                  active_s;
    logic                  busy_s;
    logic                  calc_start_s;

    // Multiplier operands straight from the register file; the multiplier latches them on start.
    always_comb begin
        if (divisor_latch == {DL_WIDTH{1'b0}}) begin
            mcand_s = {1'b1, {DL_WIDTH{1'b0}}};
        end else begin
            mcand_s = {1'b0, divisor_latch};
        end
        mplier_s = {1'b0, psd} + {{PSD_WIDTH{1'b0}}, 1'b1};
    end

    shift_mult #(
        .A_WIDTH (A_W),
        .B_WIDTH (B_W),
        .P_WIDTH (P_W)
    ) u_mult (
        .clk          (clk),
        .rst_n        (!reset),
        .srst         (1'b0),
        .start        (calc_start_r),
        .multiplicand (mcand_s),
        .multiplier   (mplier_s),
        .product      (product_s),
        .done         (mult_done_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state; a done seen on a restart cycle belongs to the aborted multiply.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: next_state_s = CALC;
            CALC: begin
                if (new_baud) begin
                    next_state_s = CALC;
                end else if (mult_done_s && !calc_start_r) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = CALC;
                end
            end
            RUN: begin
                if (new_baud) begin
                    next_state_s = CALC;
                end else begin
                    next_state_s = RUN;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Output decode from the next state so the registered flags line up with state_r.
    always_comb begin
        active_s     = (next_state_s == RUN);
        busy_s       = (next_state_s == CALC);
        calc_start_s = (next_state_s == CALC) && ((state_r != CALC) || new_baud);
    end

    // Tick event and fractional arithmetic.
    always_comb begin
        frac_sum_s   = {1'b0, acc_r} + {1'b0, dld_r};
        reload_s     = period_r + {{(P_W-1){1'b0}}, extra_r};
        count_en_s   = enable_sample | enable_baud;
        event_s      = (state_r == RUN) && !new_baud && count_en_s && (cnt_r == ONE_P);
        last_phase_s = osr_last_phase(osr_r);
    end

    // Capture the fractional addend and OSR together with the multiplier operands.
    always_ff @(posedge clk) begin
        if (reset) begin
            dld_r <= {FRAC_WIDTH{1'b0}};
            osr_r <= OSR_16;
        end else if (calc_start_r) begin
            dld_r <= dld;
            osr_r <= osr_sel_t'(osr_sel);
        end
    end

    // Period counter, fractional accumulator and baud phase; all restart outside RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            period_r <= {P_W{1'b0}};
            cnt_r    <= {P_W{1'b0}};
            acc_r    <= {FRAC_WIDTH{1'b0}};
            extra_r  <= 1'b0;
            phase_r  <= 4'd0;
        end else if ((state_r != RUN) || new_baud) begin
            period_r <= product_s;
            cnt_r    <= product_s;
            acc_r    <= {FRAC_WIDTH{1'b0}};
            extra_r  <= 1'b0;
            phase_r  <= 4'd0;
        end else begin
            if (!count_en_s) begin
                cnt_r <= reload_s;
            end else if (event_s) begin
                cnt_r   <= period_r + {{(P_W-1){1'b0}}, frac_sum_s[FRAC_WIDTH]};
                acc_r   <= frac_sum_s[FRAC_WIDTH-1:0];
                extra_r <= frac_sum_s[FRAC_WIDTH];
            end else begin
                cnt_r <= cnt_r - ONE_P;
            end
            if (!enable_baud) begin
                phase_r <= 4'd0;
            end else if (event_s) begin
                phase_r <= (phase_r == last_phase_s) ? 4'd0 : phase_r + 4'd1;
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_tick_r <= 1'b0;
            baud_tick_r   <= 1'b0;
            active_r      <= 1'b0;
            busy_r        <= 1'b0;
            calc_start_r  <= 1'b0;
        end else begin
            sample_tick_r <= event_s && enable_sample;
            baud_tick_r   <= event_s && enable_baud && (phase_r == last_phase_s);
            active_r      <= active_s;
            busy_r        <= busy_s;
            calc_start_r  <= calc_start_s;
        end
    end

    assign sample_tick = sample_tick_r;
    assign baud_tick   = baud_tick_r;
    assign active      = active_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed bench for baud_gen_frac: tick positions are compared cycle by cycle
// against hand-derived period sequences counted from the first RUN cycle.
module tb_baud_gen_frac;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] divisor_latch = 16'd1;
    logic [3:0]  psd = 4'd0;
    logic [3:0]  dld = 4'd0;
    logic [1:0]  osr_sel = 2'd0;
    logic        new_baud = 1'b0;
    logic        enable_sample = 1'b1;
    logic        enable_baud = 1'b1;
    logic        sample_tick;
    logic        baud_tick;
    logic        active;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic obs_s [0:199];
    logic obs_b [0:199];
    bit   exp_s [0:199];
    bit   exp_b [0:199];

    baud_gen_frac dut (
        .clk           (clk),
        .reset         (reset),
        .divisor_latch (divisor_latch),
        .psd           (psd),
        .dld           (dld),
        .osr_sel       (osr_sel),
        .new_baud      (new_baud),
        .enable_sample (enable_sample),
        .enable_baud   (enable_baud),
        .sample_tick   (sample_tick),
        .baud_tick     (baud_tick),
        .active        (active),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [15:0] dl, input logic [3:0] p, input logic [3:0] d,
                           input logic [1:0] o, input logic es, input logic eb);
        divisor_latch = dl;
        psd           = p;
        dld           = d;
        osr_sel       = o;
        enable_sample = es;
        enable_baud   = eb;
    endtask

    task automatic pulse_new_baud();
        new_baud = 1'b1;
        tick();
        new_baud = 1'b0;
    endtask

    // Returns the number of cycles until active is seen (99 if it never rises).
    task automatic wait_active(output int n);
        n = 99;
        for (int i = 1; i <= 20 && n == 99; i++) begin
            tick();
            if (active === 1'b1) n = i;
        end
    endtask

    task automatic collect(input int len);
        for (int k = 1; k <= len; k++) begin
            tick();
            obs_s[k] = sample_tick;
            obs_b[k] = baud_tick;
        end
    endtask

    // Event positions: first at 'first', then gaps alternate pa, pb; baud on every osr-th event.
    task automatic build_exp(input int len, input int first, input int pa, input int pb,
                             input int osr, input bit s_en);
        int t;
        int idx;
        for (int k = 0; k < 200; k++) begin
            exp_s[k] = 1'b0;
            exp_b[k] = 1'b0;
        end
        t = first;
        idx = 0;
        while (t <= len) begin
            idx++;
            exp_s[t] = s_en;
            exp_b[t] = (idx % osr == 0);
            t += (idx % 2 == 1) ? pa : pb;
        end
    endtask

    task automatic test_reset();
        set_cfg(16'd1, 4'd0, 4'd0, 2'd0, 1'b1, 1'b1);
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({sample_tick, baud_tick, active, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0000", {sample_tick, baud_tick, active, busy});
        end
        reset = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b1 || active !== 1'b0) begin
            errors++;
            $display("FAIL reset_release busy=%b active=%b want busy=1 active=0", busy, active);
        end
    endtask

    task automatic test_every_cycle();
        int n;
        wait_active(n);
        checks++;
        if (n < 1 || n > 7) begin
            errors++;
            $display("FAIL n1_calc_len got %0d want 1..7", n);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL n1_busy_run got %b want 0", busy);
        end
        collect(48);
        build_exp(48, 1, 1, 1, 16, 1'b1);
        for (int k = 1; k <= 48; k++) begin
            checks++;
            if (obs_s[k] !== exp_s[k] || obs_b[k] !== exp_b[k]) begin
                errors++;
                $display("FAIL n1 k=%0d sample,baud=%b%b want %b%b", k, obs_s[k], obs_b[k], exp_s[k], exp_b[k]);
            end
        end
    endtask

    task automatic test_fractional();
        int n;
        set_cfg(16'd3, 4'd0, 4'd8, 2'd0, 1'b1, 1'b1);
        pulse_new_baud();
        checks++;
        if (busy !== 1'b1 || active !== 1'b0) begin
            errors++;
            $display("FAIL frac_busy busy=%b active=%b want 1 0", busy, active);
        end
        wait_active(n);
        checks++;
        if (n < 1 || n > 7) begin
            errors++;
            $display("FAIL frac_calc_len got %0d want 1..7", n);
        end
        collect(120);
        build_exp(120, 3, 3, 4, 16, 1'b1);
        for (int k = 1; k <= 120; k++) begin
            checks++;
            if (obs_s[k] !== exp_s[k] || obs_b[k] !== exp_b[k]) begin
                errors++;
                $display("FAIL frac k=%0d sample,baud=%b%b want %b%b", k, obs_s[k], obs_b[k], exp_s[k], exp_b[k]);
            end
        end
    endtask

    task automatic test_prescale();
        int n;
        set_cfg(16'd5, 4'd1, 4'd0, 2'd2, 1'b1, 1'b1);
        pulse_new_baud();
        wait_active(n);
        checks++;
        if (n < 1 || n > 7) begin
            errors++;
            $display("FAIL psd_calc_len got %0d want 1..7", n);
        end
        // Input changes after capture must not alter the running period.
        set_cfg(16'd7, 4'd0, 4'd3, 2'd0, 1'b1, 1'b1);
        collect(90);
        build_exp(90, 10, 10, 10, 4, 1'b1);
        for (int k = 1; k <= 90; k++) begin
            checks++;
            if (obs_s[k] !== exp_s[k] || obs_b[k] !== exp_b[k]) begin
                errors++;
                $display("FAIL psd k=%0d sample,baud=%b%b want %b%b", k, obs_s[k], obs_b[k], exp_s[k], exp_b[k]);
            end
        end
    endtask

    task automatic test_recompute();
        int n;
        set_cfg(16'd4, 4'd0, 4'd0, 2'd0, 1'b1, 1'b1);
        pulse_new_baud();
        wait_active(n);
        collect(11);
        build_exp(11, 4, 4, 4, 16, 1'b1);
        for (int k = 1; k <= 11; k++) begin
            checks++;
            if (obs_s[k] !== exp_s[k] || obs_b[k] !== exp_b[k]) begin
                errors++;
                $display("FAIL rec_pre k=%0d sample,baud=%b%b want %b%b", k, obs_s[k], obs_b[k], exp_s[k], exp_b[k]);
            end
        end
        // A tick would be due on the next cycle; new_baud must suppress it.
        divisor_latch = 16'd2;
        pulse_new_baud();
        checks++;
        if (sample_tick !== 1'b0 || busy !== 1'b1 || active !== 1'b0) begin
            errors++;
            $display("FAIL rec_stop tick=%b busy=%b active=%b want 0 1 0", sample_tick, busy, active);
        end
        wait_active(n);
        checks++;
        if (n < 1 || n > 7) begin
            errors++;
            $display("FAIL rec_calc_len got %0d want 1..7", n);
        end
        collect(34);
        build_exp(34, 2, 2, 2, 16, 1'b1);
        for (int k = 1; k <= 34; k++) begin
            checks++;
            if (obs_s[k] !== exp_s[k] || obs_b[k] !== exp_b[k]) begin
                errors++;
                $display("FAIL rec_post k=%0d sample,baud=%b%b want %b%b", k, obs_s[k], obs_b[k], exp_s[k], exp_b[k]);
            end
        end
    endtask

    task automatic test_baud_only();
        int n;
        set_cfg(16'd2, 4'd0, 4'd0, 2'd1, 1'b0, 1'b1);
        pulse_new_baud();
        wait_active(n);
        collect(40);
        build_exp(40, 2, 2, 2, 8, 1'b0);
        for (int k = 1; k <= 40; k++) begin
            checks++;
            if (obs_s[k] !== exp_s[k] || obs_b[k] !== exp_b[k]) begin
                errors++;
                $display("FAIL bonly k=%0d sample,baud=%b%b want %b%b", k, obs_s[k], obs_b[k], exp_s[k], exp_b[k]);
            end
        end
    endtask

    task automatic test_reset_midway();
        int n;
        set_cfg(16'd3, 4'd0, 4'd0, 2'd0, 1'b1, 1'b1);
        pulse_new_baud();
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({sample_tick, baud_tick, active, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_calc got %b want 0000", {sample_tick, baud_tick, active, busy});
        end
        reset = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_calc_rel busy=%b want 1", busy);
        end
        wait_active(n);
        collect(10);
        build_exp(10, 3, 3, 3, 16, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            checks++;
            if (obs_s[k] !== exp_s[k] || obs_b[k] !== exp_b[k]) begin
                errors++;
                $display("FAIL rst_n3 k=%0d sample,baud=%b%b want %b%b", k, obs_s[k], obs_b[k], exp_s[k], exp_b[k]);
            end
        end
        divisor_latch = 16'd2;
        reset = 1'b1;
        new_baud = 1'b1;
        tick();
        checks++;
        if ({sample_tick, baud_tick, active, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_nb got %b want 0000", {sample_tick, baud_tick, active, busy});
        end
        reset = 1'b0;
        new_baud = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b1 || active !== 1'b0) begin
            errors++;
            $display("FAIL rst_nb_rel busy=%b active=%b want 1 0", busy, active);
        end
        wait_active(n);
        collect(12);
        build_exp(12, 2, 2, 2, 16, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            checks++;
            if (obs_s[k] !== exp_s[k] || obs_b[k] !== exp_b[k]) begin
                errors++;
                $display("FAIL rst_n2 k=%0d sample,baud=%b%b want %b%b", k, obs_s[k], obs_b[k], exp_s[k], exp_b[k]);
            end
        end
    endtask

    task automatic test_max_divisor();
        int n;
        int first;
        set_cfg(16'd0, 4'd0, 4'd0, 2'd0, 1'b1, 1'b1);
        pulse_new_baud();
        wait_active(n);
        first = 0;
        for (int k = 1; k <= 65600 && first == 0; k++) begin
            tick();
            if (sample_tick === 1'b1) first = k;
        end
        checks++;
        if (first != 65536) begin
            errors++;
            $display("FAIL dl_zero first tick at %0d want 65536", first);
        end
    endtask

    initial begin
        test_reset();
        test_every_cycle();
        test_fractional();
        test_prescale();
        test_recompute();
        test_baud_only();
        test_reset_midway();
        test_max_divisor();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
